// File: rtl/rx_intf_m_axis_arbiter.sv
// Purpose: round-robin share of the rx m_axis/S2MM channel between the wifi rx path (0) and IQ capture (1).
// Latency: request to registered grant is 1 cycle; data/valid/start are muxed combinationally from the owner.
// Backpressure: ownership is held until m_axis_tlast, abort or timeout, then an idle gap precedes the next grant.
module rx_intf_m_axis_arbiter #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int TIMEOUT_WIDTH          = 13,
  parameter int RST_CYCLES             = 8,
  parameter int GAP_CYCLES             = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req0,
  input  logic                              req1,
  input  logic                              start0,
  input  logic                              start1,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] data0,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] data1,
  input  logic                              valid0,
  input  logic                              valid1,
  input  logic                              m_axis_tlast,
  input  logic                              tsf_pulse_1M,
  input  logic                              timeout_en,
  input  logic [TIMEOUT_WIDTH-1:0]          timeout_top,
  output logic                              gnt0,
  output logic                              gnt1,
  output logic                              start_1trans_to_m_axis,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_to_m_axis_out,
  output logic                              data_ready_to_m_axis_out,
  output logic                              m_axis_rst,
  output logic                              timeout_pulse,
  output logic                              owner,
  output logic                              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_XFER    = 3'd2,
    S_RECOVER = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  // One counter serves both the recovery hold and the idle gap.
  localparam int CNT_MAX = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t                   r_state, w_state_nxt;
  logic                     r_gnt0, w_gnt0_nxt;
  logic                     r_gnt1, w_gnt1_nxt;
  logic                     r_owner, w_owner_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_timer, w_timer_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic                     r_m_axis_rst, w_m_axis_rst_nxt;
  logic                     r_timeout_pulse, w_timeout_pulse_nxt;
  logic                     w_start_out;

  logic                     w_own_req;
  logic                     w_own_start;
  logic                     w_own_valid;
  logic                     w_win;
  logic                     w_timeout;
  logic [TIMEOUT_WIDTH-1:0] w_timer_inc;

  assign w_own_req   = r_owner ? req1   : req0;
  assign w_own_start = r_owner ? start1 : start0;
  assign w_own_valid = r_owner ? valid1 : valid0;
  // On a tie the previous owner yields; a lone request simply wins.
  assign w_win       = (req0 && req1) ? ~r_owner : req1;
  assign w_timeout   = timeout_en && (r_timer > timeout_top);
  assign w_timer_inc = (tsf_pulse_1M && (r_timer != '1)) ? (r_timer + 1'b1) : r_timer;

  // State and output registers; reset drops any transfer without a recovery pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_gnt0          <= 1'b0;
      r_gnt1          <= 1'b0;
      r_owner         <= 1'b1;
      r_timer         <= '0;
      r_cnt           <= '0;
      r_m_axis_rst    <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_gnt0          <= w_gnt0_nxt;
      r_gnt1          <= w_gnt1_nxt;
      r_owner         <= w_owner_nxt;
      r_timer         <= w_timer_nxt;
      r_cnt           <= w_cnt_nxt;
      r_m_axis_rst    <= w_m_axis_rst_nxt;
      r_timeout_pulse <= w_timeout_pulse_nxt;
    end
  end

  // Next-state, grant, timer and recovery decisions.
  always_comb begin
    w_state_nxt         = r_state;
    w_gnt0_nxt          = r_gnt0;
    w_gnt1_nxt          = r_gnt1;
    w_owner_nxt         = r_owner;
    w_timer_nxt         = r_timer;
    w_cnt_nxt           = r_cnt;
    w_m_axis_rst_nxt    = r_m_axis_rst;
    w_timeout_pulse_nxt = 1'b0;
    w_start_out         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_owner_nxt = w_win;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_timer_nxt = '0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        w_timer_nxt = w_timer_inc;
        w_start_out = w_own_start;
        if (w_own_start) begin
          w_state_nxt = S_XFER;
        end else if (!w_own_req) begin
          w_gnt0_nxt  = 1'b0;
          w_gnt1_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else if (w_timeout) begin
          w_gnt0_nxt          = 1'b0;
          w_gnt1_nxt          = 1'b0;
          w_m_axis_rst_nxt    = 1'b1;
          w_timeout_pulse_nxt = 1'b1;
          w_cnt_nxt           = '0;
          w_state_nxt         = S_RECOVER;
        end
      end
      S_XFER: begin
        w_timer_nxt = w_timer_inc;
        // A tlast in the same cycle as the timeout is a clean finish.
        if (m_axis_tlast) begin
          w_gnt0_nxt  = 1'b0;
          w_gnt1_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else if (w_timeout) begin
          w_gnt0_nxt          = 1'b0;
          w_gnt1_nxt          = 1'b0;
          w_m_axis_rst_nxt    = 1'b1;
          w_timeout_pulse_nxt = 1'b1;
          w_cnt_nxt           = '0;
          w_state_nxt         = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (r_cnt == RST_LAST) begin
          w_m_axis_rst_nxt = 1'b0;
          w_cnt_nxt        = '0;
          w_state_nxt      = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign gnt0                     = r_gnt0;
  assign gnt1                     = r_gnt1;
  assign owner                    = r_owner;
  assign m_axis_rst               = r_m_axis_rst;
  assign timeout_pulse            = r_timeout_pulse;
  assign busy                     = (r_state != S_IDLE);
  assign start_1trans_to_m_axis   = w_start_out;
  assign data_to_m_axis_out       = r_owner ? data1 : data0;
  assign data_ready_to_m_axis_out = ((r_state == S_GRANT) || (r_state == S_XFER)) && w_own_valid;

endmodule
